// File: rtl/mem_responder.sv
// Purpose : single-port 32-bit word memory answering one req/ack access at a time.
// Latency : req sampled in IDLE in cycle N -> one-cycle ack in cycle N+LATENCY+1.
// Backpr. : initiator holds req until ack; new requests are ignored while busy.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req, we           access request, 1 = store / 0 = load (sampled with req)
//   addr, wdata       byte address and store data (sampled with req)
//   rdata, ack, err   response data, completion pulse, error flag (valid with ack)
//   busy              high from capture until the ack cycle inclusive
module mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                mem_we;
  logic                bad_addr;
  logic [ADDR_W-1:0]   word_idx;

  logic [31:0] mem_q [2**ADDR_W];

  assign word_idx = addr_q[ADDR_W+1:2];
  // Misaligned, or any address bit above the stored word range is set.
  assign bad_addr = (addr_q[1:0] != 2'b00) || ((addr_q >> (ADDR_W + 2)) != 32'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = 32'd0;
    err_d   = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = 4'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Perform the access on the edge entering RESP so rdata/err are
          // registered and appear together with ack.
          state_d = RESP;
          err_d   = bad_addr;
          if (!bad_addr) begin
            if (we_q) mem_we  = 1'b1;
            else      rdata_d = mem_q[word_idx];
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage survives reset; a reset on the write edge aborts the store.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[word_idx] <= wdata_q;
    end
  end

  assign ack   = (state_q == RESP);
  assign busy  = (state_q != IDLE);
  assign rdata = rdata_q;
  assign err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        req0 = 1'b0, we0 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0;
  logic [31:0] rdata0;
  logic        ack0, err0, busy0;

  logic        req1 = 1'b0, we1 = 1'b0;
  logic [31:0] addr1 = '0, wdata1 = '0;
  logic [31:0] rdata1;
  logic        ack1, err1, busy1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(8), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .ack(ack0), .err(err0), .busy(busy0)
  );

  mem_responder #(.ADDR_W(8), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
    .rdata(rdata1), .ack(ack1), .err(err1), .busy(busy1)
  );

  task automatic drive(input int sel, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel == 0) begin
      req0 = r; we0 = w; addr0 = a; wdata0 = d;
    end else begin
      req1 = r; we1 = w; addr1 = a; wdata1 = d;
    end
  endtask

  // Issues one access and measures edges from acceptance to ack (-1 = timeout).
  // Inputs are scrambled after capture; the DUT must use its captured copy.
  task automatic access(input int sel, input logic w, input logic [31:0] a,
                        input logic [31:0] d, output int lat,
                        output logic [31:0] rd, output logic e);
    logic got;
    lat = -1; rd = '0; e = 1'b0;
    drive(sel, 1'b1, w, a, d);
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 1) drive(sel, 1'b1, ~w, a ^ 32'h4, ~d);
      got = (sel == 0) ? ack0 : ack1;
      if (got) begin
        lat = i;
        rd  = (sel == 0) ? rdata0 : rdata1;
        e   = (sel == 0) ? err0 : err1;
        break;
      end
    end
    drive(sel, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (ack0 !== 1'b0)    begin bad++; $display("FAIL reset_ack got=%b exp=0", ack0); end
    total++; if (err0 !== 1'b0)    begin bad++; $display("FAIL reset_err got=%b exp=0", err0); end
    total++; if (busy0 !== 1'b0)   begin bad++; $display("FAIL reset_busy got=%b exp=0", busy0); end
    total++; if (rdata0 !== 32'd0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rdata0); end
    total++; if (busy1 !== 1'b0)   begin bad++; $display("FAIL reset_busy1 got=%b exp=0", busy1); end
    rst = 1'b0;
  endtask

  task automatic test_store_load();
    int lat; logic [31:0] rd; logic e;
    access(0, 1'b1, 32'h10, 32'hDEADBEEF, lat, rd, e);
    total++; if (lat !== 3)     begin bad++; $display("FAIL st_lat got=%0d exp=3", lat); end
    total++; if (e !== 1'b0)    begin bad++; $display("FAIL st_err got=%b exp=0", e); end
    total++; if (rd !== 32'd0)  begin bad++; $display("FAIL st_rdata got=%h exp=0", rd); end
    access(0, 1'b0, 32'h10, 32'h0, lat, rd, e);
    total++; if (lat !== 3)     begin bad++; $display("FAIL ld_lat got=%0d exp=3", lat); end
    total++; if (e !== 1'b0)    begin bad++; $display("FAIL ld_err got=%b exp=0", e); end
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL ld_rdata got=%h exp=deadbeef", rd); end
    total++; if (rdata0 !== 32'd0 || err0 !== 1'b0 || busy0 !== 1'b0)
      begin bad++; $display("FAIL idle_outs got=%h/%b/%b exp=0/0/0", rdata0, err0, busy0); end
  endtask

  task automatic test_misaligned();
    int lat; logic [31:0] rd; logic e;
    access(0, 1'b1, 32'h13, 32'h1, lat, rd, e);
    total++; if (lat !== 3)    begin bad++; $display("FAIL mis_lat got=%0d exp=3", lat); end
    total++; if (e !== 1'b1)   begin bad++; $display("FAIL mis_err got=%b exp=1", e); end
    total++; if (rd !== 32'd0) begin bad++; $display("FAIL mis_rdata got=%h exp=0", rd); end
    access(0, 1'b0, 32'h10, 32'h0, lat, rd, e);
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL mis_keep got=%h exp=deadbeef", rd); end
  endtask

  task automatic test_out_of_range();
    int lat; logic [31:0] rd; logic e;
    access(0, 1'b1, 32'h0, 32'h00000A0A, lat, rd, e);
    access(0, 1'b0, 32'h400, 32'h0, lat, rd, e);
    total++; if (e !== 1'b1)   begin bad++; $display("FAIL oor_ld_err got=%b exp=1", e); end
    total++; if (rd !== 32'd0) begin bad++; $display("FAIL oor_ld_rdata got=%h exp=0", rd); end
    access(0, 1'b1, 32'h400, 32'h55555555, lat, rd, e);
    total++; if (e !== 1'b1)   begin bad++; $display("FAIL oor_st_err got=%b exp=1", e); end
    access(0, 1'b0, 32'h0, 32'h0, lat, rd, e);
    total++; if (rd !== 32'h00000A0A) begin bad++; $display("FAIL oor_no_write got=%h exp=00000a0a", rd); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd; logic e;
    logic exp_ack, exp_busy;
    access(0, 1'b1, 32'h4, 32'h44444444, lat, rd, e);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk); #1;
      exp_ack  = (i == 3) || (i == 7);
      exp_busy = !((i == 4) || (i == 8) || (i == 9));
      total++; if (ack0 !== exp_ack)   begin bad++; $display("FAIL b2b_ack[%0d] got=%b exp=%b", i, ack0, exp_ack); end
      total++; if (busy0 !== exp_busy) begin bad++; $display("FAIL b2b_busy[%0d] got=%b exp=%b", i, busy0, exp_busy); end
      if (i == 3) begin
        total++; if (rdata0 !== 32'h00000A0A) begin bad++; $display("FAIL b2b_rdata0 got=%h exp=00000a0a", rdata0); end
        addr0 = 32'h4;
      end
      if (i == 7) begin
        total++; if (rdata0 !== 32'h44444444) begin bad++; $display("FAIL b2b_rdata1 got=%h exp=44444444", rdata0); end
        req0 = 1'b0; addr0 = 32'h0;
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat; int acks; logic [31:0] rd; logic e;
    access(0, 1'b1, 32'h20, 32'h11111111, lat, rd, e);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; wdata0 = 32'hCAFEF00D;
    @(posedge clk); #1;
    total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL rm_accept got=%b exp=1", busy0); end
    rst = 1'b1; req0 = 1'b0;
    @(posedge clk); #1;
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL rm_busy got=%b exp=0", busy0); end
    total++; if (ack0 !== 1'b0)  begin bad++; $display("FAIL rm_ack got=%b exp=0", ack0); end
    rst = 1'b0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ack0) acks++;
    end
    total++; if (acks !== 0) begin bad++; $display("FAIL rm_no_ack got=%0d exp=0", acks); end
    access(0, 1'b0, 32'h20, 32'h0, lat, rd, e);
    total++; if (lat !== 3) begin bad++; $display("FAIL rm_after_lat got=%0d exp=3", lat); end
    total++; if (rd !== 32'h11111111) begin bad++; $display("FAIL rm_keep got=%h exp=11111111", rd); end
  endtask

  task automatic test_latency1_sweep();
    logic [31:0] ref_mem [16];
    int lat; logic [31:0] rd; logic e;
    logic w, mis; int idx; logic [31:0] a, d, exp_rd;
    for (int k = 0; k < 16; k++) begin
      ref_mem[k] = 32'h10000000 + 32'(k) * 32'h01010101;
      access(1, 1'b1, 32'(k * 4), ref_mem[k], lat, rd, e);
      total++; if (lat !== 2) begin bad++; $display("FAIL l1_init_lat[%0d] got=%0d exp=2", k, lat); end
    end
    for (int n = 0; n < 200; n++) begin
      w   = 1'($urandom_range(0, 1));
      idx = int'($urandom_range(0, 15));
      mis = ($urandom_range(0, 7) == 0);
      a   = 32'(idx * 4) + (mis ? 32'($urandom_range(1, 3)) : 32'd0);
      d   = $urandom;
      exp_rd = (w || mis) ? 32'd0 : ref_mem[idx];
      access(1, w, a, d, lat, rd, e);
      if (w && !mis) ref_mem[idx] = d;
      total++; if (lat !== 2)    begin bad++; $display("FAIL l1_lat[%0d] got=%0d exp=2", n, lat); end
      total++; if (e !== mis)    begin bad++; $display("FAIL l1_err[%0d] got=%b exp=%b", n, e, mis); end
      total++; if (rd !== exp_rd) begin bad++; $display("FAIL l1_rdata[%0d] addr=%h got=%h exp=%h", n, a, rd, exp_rd); end
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_misaligned();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
    test_latency1_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning log2 of the number of 32-bit words stored.
REQ-002 The block SHALL have parameter LATENCY, default 2, meaning wait cycles before a request is serviced; legal range 1..15.
REQ-003 Port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port req  input  1  the initiator requests an access; held high until ack.
REQ-006 Port we  input  1  1 = store, 0 = load; sampled with req.
REQ-007 Port addr  input  32  byte address; sampled with req.
REQ-008 Port wdata  input  32  store data; sampled with req.
REQ-009 Port rdata  output  32  load data; valid only while ack=1.
REQ-010 Port ack  output  1  one-cycle completion pulse.
REQ-011 Port err  output  1  error flag; valid only while ack=1.
REQ-012 Port busy  output  1  high while a request is captured and not yet acknowledged.

Function
REQ-013 The block SHALL store 2^ADDR_W words of 32 bits, indexed by addr[ADDR_W+1:2].
REQ-014 The FSM SHALL have the states IDLE, WAIT and RESP, and no others.
REQ-015 In IDLE with req=1, the block SHALL capture we, addr and wdata, load the wait counter with LATENCY-1 and go to WAIT.
REQ-016 In IDLE with req=0, the block SHALL stay in IDLE with ack=0 and busy=0.
REQ-017 In WAIT with counter>0, the block SHALL decrement the counter and stay in WAIT.
REQ-018 In WAIT with counter=0, the block SHALL perform the captured access and go to RESP.
- Store: write the word.
- Load: register the word into rdata.
REQ-019 In RESP, the block SHALL drive ack=1 for exactly one cycle and return to IDLE.
REQ-020 If req is sampled in IDLE in cycle N, ack SHALL be high in cycle N+LATENCY+1 (cycle N+3 for the default).
REQ-021 The block SHALL ignore req, we, addr and wdata in WAIT and RESP; only the captured values are used.
REQ-022 If req is still high in the IDLE cycle after ack, the block SHALL accept it as a new request; sustained throughput is one access per LATENCY+2 cycles.
REQ-023 A captured address with addr[1:0]!=0 SHALL produce err=1 in RESP; the memory SHALL NOT be written and rdata SHALL be 0.
REQ-024 A captured address with any bit of addr[31:ADDR_W+2] set SHALL be handled as in REQ-023 (out of range).
REQ-025 A store SHALL drive rdata=0 in RESP.
REQ-026 Outside RESP, rdata SHALL be 0 and err SHALL be 0.
REQ-027 busy SHALL be 1 in WAIT and RESP, and 0 in IDLE.
REQ-028 A load from a word stored earlier SHALL return the most recent stored value; no forwarding is needed because accesses are serialised.

Reset
REQ-029 While rst=1, the block SHALL go to IDLE with ack=0, err=0, busy=0, rdata=0 and counter=0, overriding any state.
REQ-030 A reset asserted in WAIT before the counter=0 edge SHALL abort the request: no write takes place and no ack follows.
REQ-031 A reset asserted in RESP SHALL suppress ack in the following cycle.
REQ-032 Memory contents SHALL NOT be cleared by reset.
REQ-033 After rst deasserts, the first request SHALL be accepted in the first cycle with req=1.

Verification
REQ-034 Store, then load, same address, LATENCY=2:
- Store addr=0x10, wdata=0xDEADBEEF -> ack 3 cycles after acceptance, err=0, rdata=0.
- Then load addr=0x10 -> ack with rdata=0xDEADBEEF, err=0.
REQ-035 Misaligned store addr=0x13, wdata=0x1 -> ack with err=1, rdata=0; a later load of addr=0x10 still returns 0xDEADBEEF.
REQ-036 Out of range, ADDR_W=8: load addr=0x400 -> ack with err=1 and rdata=0.
REQ-037 Back-to-back requests:
- req held high for two loads (addr 0x0, then 0x4) -> acks exactly LATENCY+2 cycles apart.
- Each ack is one cycle wide; busy=0 only in the IDLE cycle between them.
REQ-038 Reset mid-operation:
- Store addr=0x20, wdata=0xCAFEF00D; assert rst one cycle after acceptance -> no ack; busy=0 after the reset edge.
- A later load of 0x20 returns the prior contents, not 0xCAFEF00D.
REQ-039 LATENCY=1 sweep: random mix of 200 loads and stores -> every ack lands exactly 2 cycles after acceptance, and every load matches a reference model.
